mouse_tracker: RTL and testbench

Upstream of the gun stage. Takes raw 3-byte PS/2 mouse packets, byte-at-a-time from the PS/2 receiver, and frames them with resync and timeout. It accumulates signed X/Y motion into a saturated pixel position and presents that position as bin coordinates (`bin_x`, `bin_y`, Y-up) plus the left-button level for the gun stage to consume.

---
 rtl/mouse_pkg.sv | 46 ++++
 rtl/mouse_tracker_if.sv | 28 ++
 rtl/upctr.sv | 36 +++
 rtl/mouse_tracker.sv | 212 +++++++++++++++++++++
 tb/tb_mouse_tracker.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mouse_pkg.sv
// mouse_pkg: types and constants shared by the mouse tracker and the gun stage.
//   state_t       - packet framing FSM states
//   hdr_t         - fields of PS/2 packet byte0 that are kept for the apply step
//   B0_*          - bit positions inside byte0
//   DEF_*         - default screen / bin geometry and inter-byte timeout
//   axis_delta()  - 9-bit signed {sign, magnitude} to 11-bit signed motion delta
package mouse_pkg;

    typedef enum logic [1:0] {
        S_B0 = 2'd0,
        S_B1 = 2'd1,
        S_B2 = 2'd2
    } state_t;

    localparam int B0_LEFT  = 0;
    localparam int B0_SYNC  = 3;
    localparam int B0_XSIGN = 4;
    localparam int B0_YSIGN = 5;
    localparam int B0_XOVF  = 6;
    localparam int B0_YOVF  = 7;

    localparam int DEF_BIN_W    = 6;
    localparam int DEF_BIN_SIZE = 10;
    localparam int DEF_MAX_X    = 640;
    localparam int DEF_MAX_Y    = 480;
    localparam int DEF_TIMEOUT  = 100_000;

    typedef struct packed {
        logic y_ovf;
        logic x_ovf;
        logic y_sign;
        logic x_sign;
        logic left;
    } hdr_t;

    // An overflowed axis contributes no motion.
    function automatic logic signed [10:0] axis_delta(input logic       sign,
                                                      input logic [7:0] mag,
                                                      input logic       ovf);
        if (ovf) begin
            return '0;
        end
        return {{3{sign}}, mag};
    endfunction

endpackage

// File: rtl/mouse_tracker_if.sv
// mouse_tracker_if: byte stream from the PS/2 receiver and the position/button
// outputs consumed by the gun stage.
//   byte_in/byte_valid          - received byte and its one-cycle strobe
//   bin_x/bin_y                 - position in bins (Y-up)
//   button_left/pkt_valid       - left button level, new-packet pulse
//   err_cnt                     - dropped byte/packet count
// Modports: master = byte source / output consumer, slave = tracker.
interface mouse_tracker_if #(
    parameter int BIN_W = 6
);
    logic [7:0]       byte_in;
    logic             byte_valid;
    logic [BIN_W-1:0] bin_x;
    logic [BIN_W-1:0] bin_y;
    logic             button_left;
    logic             pkt_valid;
    logic [7:0]       err_cnt;

    modport master (
        output byte_in, byte_valid,
        input  bin_x, bin_y, button_left, pkt_valid, err_cnt
    );

    modport slave (
        input  byte_in, byte_valid,
        output bin_x, bin_y, button_left, pkt_valid, err_cnt
    );
endinterface

// File: rtl/upctr.sv
// upctr: free-running up-counter with synchronous clear and terminal flag.
//   clk, rst_n - clock, asynchronous active-low reset
//   clr        - synchronous clear (wins over en)
//   en         - count enable
//   done       - counter holds L-1, i.e. the next enabled clock reaches L
module upctr #(
    parameter int W = 8,
    parameter int L = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic done
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == W'(L - 1));
endmodule

// File: rtl/mouse_tracker.sv
// mouse_tracker: frames 3-byte PS/2 mouse packets, accumulates motion into a
// clamped pixel position and presents it as bins plus the left button.
//   clk, reset_n - clock, asynchronous active-low reset
//   mif (slave)  - byte_in/byte_valid in; bin_x, bin_y, button_left,
//                  pkt_valid, err_cnt out
// Optional feature: define MOUSE_TRACKER_ERRCNT_EN for a live saturating
// err_cnt; otherwise err_cnt is tied to zero.
//
// state | meaning
// S_B0  | waiting for byte0 (bit3 set), other bytes dropped
// S_B1  | byte0 held, waiting for X
// S_B2  | byte0 and X held, waiting for Y
module mouse_tracker
    import mouse_pkg::*;
#(
    parameter int BIN_W    = DEF_BIN_W,
    parameter int BIN_SIZE = DEF_BIN_SIZE,
    parameter int MAX_X    = DEF_MAX_X,
    parameter int MAX_Y    = DEF_MAX_Y,
    parameter int TIMEOUT  = DEF_TIMEOUT
) (
    input  logic            clk,
    input  logic            reset_n,
    mouse_tracker_if.slave  mif
);
    localparam logic [9:0]         POS_X_RST = 10'(MAX_X / 2);
    localparam logic [9:0]         POS_Y_RST = 10'(MAX_Y / 2);
    localparam logic [BIN_W-1:0]   BIN_X_RST = BIN_W'((MAX_X / 2) / BIN_SIZE);
    localparam logic [BIN_W-1:0]   BIN_Y_RST = BIN_W'((MAX_Y / 2) / BIN_SIZE);
    localparam logic signed [10:0] X_HI      = 11'(MAX_X - 1);
    localparam logic signed [10:0] Y_HI      = 11'(MAX_Y - 1);

    state_t             state_q, state_d;
    hdr_t               hdr_q, hdr_d;
    logic [7:0]         x_q, x_d;
    logic               apply_q, apply_d;
    logic signed [10:0] dx_q, dx_d, dy_q, dy_d;
    logic               btn_pend_q, btn_pend_d;
    logic [9:0]         pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic               btn_q, btn_d;
    logic               upd_q, upd_d;
    logic [BIN_W-1:0]   bin_x_q, bin_x_d, bin_y_q, bin_y_d;
    logic               button_left_q, button_left_d;
    logic               pkt_valid_q, pkt_valid_d;
    logic signed [10:0] sum_x, sum_y;
    logic               tmo_done;

    function automatic logic [9:0] clamp_pos(input logic signed [10:0] v,
                                             input logic signed [10:0] hi);
        if (v < 0) begin
            return '0;
        end
        if (v > hi) begin
            return hi[9:0];
        end
        return v[9:0];
    endfunction

    // Inter-byte timer: held at zero while idle and restarted by every byte.
    upctr #(
        .W ($clog2(TIMEOUT)),
        .L (TIMEOUT)
    ) u_tmo (
        .clk   (clk),
        .rst_n (reset_n),
        .clr   (mif.byte_valid || (state_q == S_B0)),
        .en    (state_q != S_B0),
        .done  (tmo_done)
    );

    // Framing FSM; an arriving byte takes priority over a same-cycle timeout.
    always_comb begin
        state_d    = state_q;
        hdr_d      = hdr_q;
        x_d        = x_q;
        apply_d    = 1'b0;
        dx_d       = dx_q;
        dy_d       = dy_q;
        btn_pend_d = btn_pend_q;
        case (state_q)
            S_B0: begin
                if (mif.byte_valid && mif.byte_in[B0_SYNC]) begin
                    hdr_d.y_ovf  = mif.byte_in[B0_YOVF];
                    hdr_d.x_ovf  = mif.byte_in[B0_XOVF];
                    hdr_d.y_sign = mif.byte_in[B0_YSIGN];
                    hdr_d.x_sign = mif.byte_in[B0_XSIGN];
                    hdr_d.left   = mif.byte_in[B0_LEFT];
                    state_d      = S_B1;
                end
            end
            S_B1: begin
                if (mif.byte_valid) begin
                    x_d     = mif.byte_in;
                    state_d = S_B2;
                end else if (tmo_done) begin
                    state_d = S_B0;
                end
            end
            S_B2: begin
                if (mif.byte_valid) begin
                    dx_d       = axis_delta(hdr_q.x_sign, x_q, hdr_q.x_ovf);
                    dy_d       = axis_delta(hdr_q.y_sign, mif.byte_in, hdr_q.y_ovf);
                    btn_pend_d = hdr_q.left;
                    apply_d    = 1'b1;
                    state_d    = S_B0;
                end else if (tmo_done) begin
                    state_d = S_B0;
                end
            end
            default: state_d = S_B0;
        endcase
    end

    // Apply pipeline: position/button one clock after the strobe, bins and
    // outputs one clock after that. Runs independently of the framing FSM.
    always_comb begin
        sum_x         = $signed({1'b0, pos_x_q}) + dx_q;
        sum_y         = $signed({1'b0, pos_y_q}) + dy_q;
        pos_x_d       = pos_x_q;
        pos_y_d       = pos_y_q;
        btn_d         = btn_q;
        upd_d         = apply_q;
        bin_x_d       = bin_x_q;
        bin_y_d       = bin_y_q;
        button_left_d = button_left_q;
        pkt_valid_d   = upd_q;
        if (apply_q) begin
            pos_x_d = clamp_pos(sum_x, X_HI);
            pos_y_d = clamp_pos(sum_y, Y_HI);
            btn_d   = btn_pend_q;
        end
        if (upd_q) begin
            bin_x_d       = BIN_W'(pos_x_q / 10'(BIN_SIZE));
            bin_y_d       = BIN_W'(pos_y_q / 10'(BIN_SIZE));
            button_left_d = btn_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_B0;
            hdr_q         <= '0;
            x_q           <= '0;
            apply_q       <= 1'b0;
            dx_q          <= '0;
            dy_q          <= '0;
            btn_pend_q    <= 1'b0;
            pos_x_q       <= POS_X_RST;
            pos_y_q       <= POS_Y_RST;
            btn_q         <= 1'b0;
            upd_q         <= 1'b0;
            bin_x_q       <= BIN_X_RST;
            bin_y_q       <= BIN_Y_RST;
            button_left_q <= 1'b0;
            pkt_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            hdr_q         <= hdr_d;
            x_q           <= x_d;
            apply_q       <= apply_d;
            dx_q          <= dx_d;
            dy_q          <= dy_d;
            btn_pend_q    <= btn_pend_d;
            pos_x_q       <= pos_x_d;
            pos_y_q       <= pos_y_d;
            btn_q         <= btn_d;
            upd_q         <= upd_d;
            bin_x_q       <= bin_x_d;
            bin_y_q       <= bin_y_d;
            button_left_q <= button_left_d;
            pkt_valid_q   <= pkt_valid_d;
        end
    end

`ifdef MOUSE_TRACKER_ERRCNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;
    logic       err_evt;

    // Drops happen only in S_B0 and timeouts only outside it, so at most one
    // event per clock.
    always_comb begin
        err_evt = 1'b0;
        if (state_q == S_B0) begin
            err_evt = mif.byte_valid && !mif.byte_in[B0_SYNC];
        end else begin
            err_evt = !mif.byte_valid && tmo_done;
        end
        err_cnt_d = err_cnt_q;
        if (err_evt && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign mif.err_cnt = err_cnt_q;
`else
    assign mif.err_cnt = 8'd0;
`endif

    assign mif.bin_x       = bin_x_q;
    assign mif.bin_y       = bin_y_q;
    assign mif.button_left = button_left_q;
    assign mif.pkt_valid   = pkt_valid_q;

endmodule

// File: tb/tb_mouse_tracker.sv
// tb_mouse_tracker: directed packets against a packet-level model of the
// tracker; outputs are compared every cycle plus hand-computed literal pins.
module tb_mouse_tracker;
    localparam int TMO   = 40;
    localparam int MAXX  = 640;
    localparam int MAXY  = 480;
    localparam int BSIZE = 10;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    mouse_tracker_if #(.BIN_W(6)) mif ();

    mouse_tracker #(
        .BIN_W    (6),
        .BIN_SIZE (BSIZE),
        .MAX_X    (MAXX),
        .MAX_Y    (MAXY),
        .TIMEOUT  (TMO)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .mif     (mif)
    );

    typedef struct {
        int due;
        int bx;
        int by;
        int btn;
    } exp_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   pulses = 0;
    bit   chk_en = 1'b0;
    exp_t exp_q[$];

    int         m_px, m_py, m_idx, m_last, m_err;
    int         cur_bx, cur_by, cur_btn;
    logic [7:0] m_b0, m_x;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int clampi(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic int delta(input bit sgn, input logic [7:0] mag, input bit ovf);
        if (ovf) return 0;
        return sgn ? int'(mag) - 256 : int'(mag);
    endfunction

    function automatic int err_exp();
`ifdef MOUSE_TRACKER_ERRCNT_EN
        return m_err;
`else
        return 0;
`endif
    endfunction

    task automatic bump_err();
        if (m_err < 255) m_err++;
    endtask

    task automatic model_reset();
        m_px = MAXX / 2;
        m_py = MAXY / 2;
        m_idx = 0;
        m_last = 0;
        m_err = 0;
        exp_q.delete();
        cur_bx = m_px / BSIZE;
        cur_by = m_py / BSIZE;
        cur_btn = 0;
    endtask

    // Byte is accepted on the clock edge following this negedge.
    task automatic send(input logic [7:0] b);
        int acc;
        @(negedge clk);
        mif.byte_in = b;
        mif.byte_valid = 1'b1;
        acc = cyc + 1;
        if (m_idx != 0 && acc - m_last > TMO) begin
            m_idx = 0;
            bump_err();
        end
        case (m_idx)
            0: begin
                if (b[3]) begin
                    m_b0 = b;
                    m_idx = 1;
                    m_last = acc;
                end else begin
                    bump_err();
                end
            end
            1: begin
                m_x = b;
                m_idx = 2;
                m_last = acc;
            end
            default: begin
                m_px = clampi(m_px + delta(m_b0[4], m_x, m_b0[6]), MAXX - 1);
                m_py = clampi(m_py + delta(m_b0[5], b, m_b0[7]), MAXY - 1);
                exp_q.push_back('{acc + 2, m_px / BSIZE, m_py / BSIZE, int'(m_b0[0])});
                m_idx = 0;
            end
        endcase
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            mif.byte_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        mif.byte_valid = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        idle(2);
    endtask

    task automatic check_err(input string nm);
        if (m_idx != 0 && cyc - m_last >= TMO) begin
            m_idx = 0;
            bump_err();
        end
        chk(nm, int'(mif.err_cnt), err_exp());
    endtask

    always @(negedge clk) begin
        if (chk_en && reset_n) begin
            int exp_pv;
            exp_pv = 0;
            if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                if (exp_q[0].due == cyc) begin
                    exp_pv = 1;
                end else begin
                    chk("pkt_late", 0, 1);
                end
                cur_bx = exp_q[0].bx;
                cur_by = exp_q[0].by;
                cur_btn = exp_q[0].btn;
                void'(exp_q.pop_front());
            end
            if (mif.pkt_valid) pulses++;
            chk("pkt_valid", int'(mif.pkt_valid), exp_pv);
            chk("bin_x", int'(mif.bin_x), cur_bx);
            chk("bin_y", int'(mif.bin_y), cur_by);
            chk("button_left", int'(mif.button_left), cur_btn);
        end
    end

    initial begin
        int p0;
        mif.byte_in = 8'h00;
        mif.byte_valid = 1'b0;
        reset_n = 1'b0;
        model_reset();
        chk_en = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        idle(2);

        // reset values
        chk("rst_bin_x", int'(mif.bin_x), 32);
        chk("rst_bin_y", int'(mif.bin_y), 24);
        chk("rst_button", int'(mif.button_left), 0);
        chk("rst_pkt_valid", int'(mif.pkt_valid), 0);
        chk("rst_err_cnt", int'(mif.err_cnt), 0);

        // basic packet with left button
        p0 = pulses;
        send(8'h09); send(8'h0A); send(8'h14); idle(6);
        chk("t1_model_px", m_px, 330);
        chk("t1_model_py", m_py, 260);
        chk("t1_bin_x", int'(mif.bin_x), 33);
        chk("t1_bin_y", int'(mif.bin_y), 26);
        chk("t1_button", int'(mif.button_left), 1);
        chk("t1_pulses", pulses - p0, 1);

        // large negative X, then clamp at 0
        do_reset();
        send(8'h18); send(8'h00); send(8'h00); idle(6);
        chk("t2a_bin_x", int'(mif.bin_x), 6);
        send(8'h18); send(8'h00); send(8'h00); idle(6);
        chk("t2b_bin_x", int'(mif.bin_x), 0);
        chk("t2b_bin_y", int'(mif.bin_y), 24);

        // resync: byte without bit3 dropped in S_B0
        do_reset();
        send(8'h02); idle(1);
        send(8'h08); send(8'h05); send(8'h05); idle(6);
        check_err("t3_err_cnt");
        chk("t3_model_px", m_px, 325);
        chk("t3_model_py", m_py, 245);
        chk("t3_bin_x", int'(mif.bin_x), 32);
        chk("t3_bin_y", int'(mif.bin_y), 24);
        chk("t3_button", int'(mif.button_left), 0);

        // timeout discards a partial packet
        do_reset();
        p0 = pulses;
        send(8'h08); idle(TMO + 10);
        check_err("t4_err_after_tmo");
        send(8'h08); send(8'h05); send(8'h05); idle(6);
        chk("t4_pulses", pulses - p0, 1);
        chk("t4_model_px", m_px, 325);
        chk("t4_bin_x", int'(mif.bin_x), 32);
        check_err("t4_err_final");

        // X overflow: X ignored, button still applies
        p0 = pulses;
        send(8'h49); send(8'h50); send(8'h00); idle(6);
        chk("t5_model_px", m_px, 325);
        chk("t5_bin_x", int'(mif.bin_x), 32);
        chk("t5_button", int'(mif.button_left), 1);
        chk("t5_pulses", pulses - p0, 1);

        // back-to-back packets on consecutive cycles
        do_reset();
        p0 = pulses;
        send(8'h09); send(8'h0A); send(8'h14);
        send(8'h18); send(8'h00); send(8'h00); idle(6);
        chk("t6_pulses", pulses - p0, 2);
        chk("t6_bin_x", int'(mif.bin_x), 7);
        chk("t6_bin_y", int'(mif.bin_y), 26);
        chk("t6_button", int'(mif.button_left), 0);

        // slow bytes within the timeout still form a packet
        send(8'h08); idle(20); send(8'h01); idle(20); send(8'h02); idle(6);
        chk("t7_model_px", m_px, 75);
        chk("t7_model_py", m_py, 262);
        check_err("t7_err_cnt");

        // reset mid-packet loses the partial packet
        send(8'h09); send(8'h0A);
        do_reset();
        p0 = pulses;
        send(8'h09); send(8'h0A); send(8'h14); idle(6);
        chk("t8_pulses", pulses - p0, 1);
        chk("t8_bin_x", int'(mif.bin_x), 33);
        chk("t8_bin_y", int'(mif.bin_y), 26);

        // Y negative to bottom clamp, then push to top-right corner
        send(8'h28); send(8'h00); send(8'h00); idle(4);
        send(8'h28); send(8'h00); send(8'h00); idle(6);
        chk("t9_bin_y_bottom", int'(mif.bin_y), 0);
        for (int i = 0; i < 5; i++) begin
            send(8'h08); send(8'h7F); send(8'h7F);
        end
        idle(6);
        chk("t9_bin_x_top", int'(mif.bin_x), 63);
        chk("t9_bin_y_top", int'(mif.bin_y), 47);

        // error counter saturation
        do_reset();
        for (int i = 0; i < 260; i++) send(8'h00);
        idle(4);
        check_err("t10_err_sat");
        send(8'h09); send(8'h01); send(8'h01); idle(6);
        chk("t10_bin_x", int'(mif.bin_x), 32);
        chk("t10_button", int'(mif.button_left), 1);

        idle(2);
        chk("end_queue_empty", exp_q.size(), 0);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
